// File: rtl/bias_buffer_loader_if.sv
// Bias-load bus: configuration, DDR read FIFO side, bias buffer bank side and status.
// The loader takes the master side. The environment (FIFO, banks, host) takes the slave side.
interface bias_buffer_loader_if #(
    parameter int DATA_LEN = 64,
    parameter int ADDR_LEN = 9,
    parameter int NUM_BANK = 2,
    parameter int CNT_LEN  = 16
);
    logic                conf;
    logic [CNT_LEN-1:0]  bias_num;
    logic [ADDR_LEN-1:0] bb_st_addr;
    logic                mode;
    logic                abort;
    logic                ddr_fifo_empty;
    logic                ddr_fifo_req;
    logic [DATA_LEN-1:0] ddr_fifo_data;
    logic [NUM_BANK-1:0] bb_wea;
    logic [ADDR_LEN-1:0] bb_addr;
    logic [DATA_LEN-1:0] bb_data;
    logic                busy;
    logic                done;
    logic [CNT_LEN-1:0]  wr_count;

    modport master (
        input  conf, bias_num, bb_st_addr, mode, abort, ddr_fifo_empty, ddr_fifo_data,
        output ddr_fifo_req, bb_wea, bb_addr, bb_data, busy, done, wr_count
    );

    modport slave (
        output conf, bias_num, bb_st_addr, mode, abort, ddr_fifo_empty, ddr_fifo_data,
        input  ddr_fifo_req, bb_wea, bb_addr, bb_data, busy, done, wr_count
    );
endinterface

// File: rtl/bias_buffer_loader.sv
// Bias buffer loader: reads a programmed number of bias words from the DDR read FIFO
// and writes them into NUM_BANK bias buffer banks. Words are either striped across the
// banks or broadcast to all banks. Addresses wrap modulo the buffer depth.
// Pipeline: a FIFO request in cycle t returns data in t+1. That data is registered
// straight into the bank write port, so the write appears in t+2.
module bias_buffer_loader #(
    parameter int DATA_LEN = 64,
    parameter int ADDR_LEN = 9,
    parameter int NUM_BANK = 2,
    parameter int CNT_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    bias_buffer_loader_if.master  bus
);
    localparam int                 BANK_SH   = $clog2(NUM_BANK);
    localparam logic [CNT_LEN-1:0] BANK_MASK = CNT_LEN'(NUM_BANK - 1);
    localparam logic [CNT_LEN-1:0] CNT_ONE   = CNT_LEN'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_LEN-1:0]  bias_q, bias_d;        // latched job length
    logic [ADDR_LEN-1:0] st_addr_q, st_addr_d;  // latched start address
    logic                mode_q, mode_d;        // latched stripe/broadcast select
    logic [CNT_LEN-1:0]  issued_q, issued_d;    // FIFO reads issued this job
    logic [CNT_LEN-1:0]  k_q, k_d;              // index of the next word to write
    logic                rd_vld_q, rd_vld_d;    // FIFO data arrives this cycle
    logic [NUM_BANK-1:0] wea_q, wea_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic [CNT_LEN-1:0]  wr_count_q, wr_count_d;
    logic                req;
    logic [NUM_BANK-1:0] onehot;
    logic [CNT_LEN-1:0]  row;

    // Next-state, FIFO request and write-stage datapath.
    always_comb begin
        state_d    = state_q;
        bias_d     = bias_q;
        st_addr_d  = st_addr_q;
        mode_d     = mode_q;
        issued_d   = issued_q;
        k_d        = k_q;
        wea_d      = '0;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_count_d = wr_count_q;
        req        = 1'b0;
        onehot     = NUM_BANK'(1) << (k_q & BANK_MASK);
        row        = mode_q ? k_q : (k_q >> BANK_SH);

        // Returning FIFO word k goes straight to the bank port.
        // Stripe picks one bank and the row within it. Broadcast writes word k at offset k everywhere.
        if (rd_vld_q) begin
            wea_d      = mode_q ? '1 : onehot;
            addr_d     = st_addr_q + ADDR_LEN'(row);
            data_d     = bus.ddr_fifo_data;
            k_d        = k_q + CNT_ONE;
            wr_count_d = wr_count_q + CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.conf) begin
                    bias_d     = bus.bias_num;
                    st_addr_d  = bus.bb_st_addr;
                    mode_d     = bus.mode;
                    issued_d   = '0;
                    k_d        = '0;
                    wr_count_d = '0;
                    state_d    = (bus.bias_num == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                req = !bus.ddr_fifo_empty && (issued_q < bias_q) && !bus.abort;
                if (req) issued_d = issued_q + CNT_ONE;
                if (bus.abort || issued_d == bias_q) state_d = S_DRAIN;
            end
            // Once no read is outstanding, the last word is already leaving the write stage.
            S_DRAIN: if (!rd_vld_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rd_vld_d = req;
    end

    // State and datapath registers. Reset drops any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bias_q     <= '0;
            st_addr_q  <= '0;
            mode_q     <= 1'b0;
            issued_q   <= '0;
            k_q        <= '0;
            rd_vld_q   <= 1'b0;
            wea_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            bias_q     <= bias_d;
            st_addr_q  <= st_addr_d;
            mode_q     <= mode_d;
            issued_q   <= issued_d;
            k_q        <= k_d;
            rd_vld_q   <= rd_vld_d;
            wea_q      <= wea_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.ddr_fifo_req = req;
    assign bus.bb_wea       = wea_q;
    assign bus.bb_addr      = addr_q;
    assign bus.bb_data      = data_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.wr_count     = wr_count_q;
endmodule

// File: tb/tb_bias_buffer_loader.sv
// Bench for bias_buffer_loader. A FIFO model serves random words.
// A monitor logs bank writes, done pulses and busy falls.
// Each job is compared against the write list computed from the striping/broadcast rules.
module tb_bias_buffer_loader;
    localparam int DL = 64, AL = 9, NB = 2, CL = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bias_buffer_loader_if #(.DATA_LEN(DL), .ADDR_LEN(AL), .NUM_BANK(NB), .CNT_LEN(CL)) ifc ();

    bias_buffer_loader #(.DATA_LEN(DL), .ADDR_LEN(AL), .NUM_BANK(NB), .CNT_LEN(CL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    int total = 0, bad = 0;
    int cyc = 0;
    logic [DL-1:0] fifo [0:4095];
    int rd_ptr = 0, obs_req = 0, viol = 0;
    logic [NB-1:0] o_wea [$];
    logic [AL-1:0] o_addr [$];
    logic [DL-1:0] o_data [$];
    int done_cnt = 0, done_cyc = 0, bfall = 0;
    logic prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data for a request shows up in the following cycle.
    always @(posedge clk) begin
        if (ifc.ddr_fifo_req === 1'b1) begin
            ifc.ddr_fifo_data <= fifo[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
            obs_req <= obs_req + 1;
            if (ifc.ddr_fifo_empty) viol <= viol + 1;
        end
    end

    // Monitor: sample DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (ifc.bb_wea != '0) begin
            o_wea.push_back(ifc.bb_wea);
            o_addr.push_back(ifc.bb_addr);
            o_data.push_back(ifc.bb_data);
        end
        if (ifc.done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (prev_busy && ifc.busy === 1'b0) bfall <= cyc;
        prev_busy <= (ifc.busy === 1'b1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req"},   ifc.ddr_fifo_req, 0);
        chk({tag, " wea"},   ifc.bb_wea, 0);
        chk({tag, " addr"},  ifc.bb_addr, 0);
        chk({tag, " data"},  ifc.bb_data, 0);
        chk({tag, " busy"},  ifc.busy, 0);
        chk({tag, " done"},  ifc.done, 0);
        chk({tag, " count"}, ifc.wr_count, 0);
    endtask

    // emp: 0 never empty, 1 empty one cycle in three, 2 random empty.
    // ab_at/rst_at: cycle offset from conf at which abort/reset is applied (-1 = never).
    // exp_done: expected done offset from conf (-1 = unchecked). exp_reads: -1 = n.
    task automatic run_job(input string tag, input int n, input int st, input bit md,
                           input int emp, input int ab_at, input bit mid, input int rst_at,
                           input int exp_done, input int exp_reads);
        int c, start, wb, r0, v0, d0, er, nw;
        logic [NB-1:0] ew;
        logic [AL-1:0] ea;
        @(negedge clk);
        start = rd_ptr; wb = o_wea.size(); r0 = obs_req; v0 = viol; d0 = done_cnt; c = cyc;
        ifc.conf = 1'b1; ifc.bias_num = CL'(n); ifc.bb_st_addr = AL'(st); ifc.mode = md;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ifc.conf       = mid && (cyc == c + 3);
            ifc.bias_num   = ifc.conf ? CL'(7) : CL'(n);
            ifc.bb_st_addr = ifc.conf ? AL'(st + 5) : AL'(st);
            ifc.mode       = ifc.conf ? ~md : md;
            case (emp)
                0:       ifc.ddr_fifo_empty = 1'b0;
                1:       ifc.ddr_fifo_empty = (cyc % 3 == 0);
                default: ifc.ddr_fifo_empty = ($urandom_range(0, 2) == 0);
            endcase
            if (ab_at >= 0 && cyc == c + ab_at) ifc.abort = 1'b1;
            if (rst_at >= 0 && cyc == c + rst_at) begin
                rst = 1'b1;
                #1;
                chk_zero({tag, " midreset"});
                @(negedge clk);
                rst = 1'b0;
                ifc.ddr_fifo_empty = 1'b0;
                return;
            end
            if (done_cnt != d0 && cyc >= done_cyc + 3) break;
        end
        ifc.conf = 1'b0; ifc.abort = 1'b0; ifc.ddr_fifo_empty = 1'b0;
        er = (exp_reads < 0) ? n : exp_reads;
        chk({tag, " done_pulses"}, done_cnt - d0, 1);
        chk({tag, " reads"}, obs_req - r0, er);
        chk({tag, " req_while_empty"}, viol - v0, 0);
        chk({tag, " wr_count"}, ifc.wr_count, er);
        if (exp_done >= 0) begin
            chk({tag, " done_cycle"}, done_cyc - c, exp_done);
            chk({tag, " busy_fall"}, bfall - c, exp_done + 1);
        end
        nw = o_wea.size() - wb;
        chk({tag, " writes"}, nw, er);
        for (int k = 0; k < er && k < nw; k++) begin
            ew = md ? '1 : NB'(1 << (k % NB));
            ea = md ? AL'(st + k) : AL'(st + k / NB);
            chk($sformatf("%s wr%0d", tag, k),
                {o_wea[wb + k], o_addr[wb + k], o_data[wb + k]}, {ew, ea, fifo[start + k]});
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) fifo[i] = {$urandom, $urandom};
        rst = 1'b1;
        ifc.conf = 1'b0; ifc.bias_num = '0; ifc.bb_st_addr = '0; ifc.mode = 1'b0;
        ifc.abort = 1'b0; ifc.ddr_fifo_empty = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        run_job("stripe13",  13,   0, 1'b0, 0, -1, 1'b0, -1, 16, -1);
        run_job("bcast4",     4, 100, 1'b1, 0, -1, 1'b0, -1,  7, -1);
        run_job("wrap8",      8, 510, 1'b0, 0, -1, 1'b0, -1, 11, -1);
        run_job("gap13",     13,   0, 1'b0, 1, -1, 1'b0, -1, -1, -1);
        run_job("abort",     13,   0, 1'b0, 0,  4, 1'b0, -1,  6,  3);
        run_job("zero",       0,  33, 1'b0, 0, -1, 1'b0, -1,  1, -1);
        run_job("conf_busy", 13,  40, 1'b0, 0, -1, 1'b1, -1, 16, -1);
        run_job("rst",       13,   0, 1'b0, 0, -1, 1'b0,  5, -1, -1);
        run_job("post_rst",   4,  20, 1'b0, 0, -1, 1'b0, -1,  7, -1);
        run_job("bcast_wrap", 6, 509, 1'b1, 0, -1, 1'b0, -1,  9, -1);
        for (int j = 0; j < 6; j++) begin
            int n, st;
            n  = $urandom_range(1, 24);
            st = $urandom_range(0, 511);
            run_job($sformatf("rnd%0d", j), n, st, 1'($urandom_range(0, 1)), 2, -1, 1'b0, -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
